// File: rtl/treasure_frame_classifier.sv
// Per-frame colour/shape classifier for an RGB332 camera stream with an N-frame vote filter.
// Publishes a registered {colour, shape} code to a consumer over a RDY/ACK handshake.
module treasure_frame_classifier #(
  parameter int WIN_X0       = 35,
  parameter int WIN_X1       = 141,
  parameter int WIN_Y0       = 28,
  parameter int WIN_Y1       = 116,
  parameter int N_BARS       = 3,
  parameter int BAR_Y0       = 47,
  parameter int BAR_PITCH    = 25,
  parameter int BAR_H        = 4,
  parameter int ACC_W        = 20,
  parameter int COLOR_MARGIN = 30,
  parameter int COLOR_MIN    = 200,
  parameter int SHAPE_MARGIN = 16,
  parameter int VOTE_FRAMES  = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] pixel_in_i,
  input  logic       href_i,
  input  logic [9:0] vga_pixel_x_i,
  input  logic [9:0] vga_pixel_y_i,
  input  logic       vga_vsync_neg_i,
  input  logic       result_ack_i,
  output logic [3:0] result_o,
  output logic       rdy_o,
  output logic       overrun_o
);

  localparam logic [9:0]       X0       = 10'(WIN_X0);
  localparam logic [9:0]       X1       = 10'(WIN_X1);
  localparam logic [9:0]       Y0       = 10'(WIN_Y0);
  localparam logic [9:0]       Y1       = 10'(WIN_Y1);
  localparam logic [ACC_W-1:0] C_MARGIN = ACC_W'(COLOR_MARGIN);
  localparam logic [ACC_W-1:0] C_MIN    = ACC_W'(COLOR_MIN);
  localparam logic [ACC_W:0]   S_MARGIN = (ACC_W+1)'(SHAPE_MARGIN);
  localparam logic [3:0]       VF       = 4'(VOTE_FRAMES);
  localparam int               MID      = N_BARS / 2;

  localparam logic [1:0] COL_NONE = 2'd0, COL_BLUE = 2'd1, COL_RED = 2'd2;
  localparam logic [1:0] SH_NONE = 2'd0, SH_TRI = 2'd1, SH_SQ = 2'd2, SH_DIA = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_COLOR, S_SHAPE, S_VOTE, S_WAIT_VS} state_e;

  state_e            state_q, state_d;
  logic              vs_q, vs_rise;
  logic              clr, pix_en, vote_en, in_x, in_y;
  logic [2:0]        pix_r, pix_g, pix_b;
  logic [N_BARS-1:0] band_hit;
  logic [ACC_W-1:0]  r_sum_q, g_sum_q, b_sum_q;
  logic [ACC_W-1:0]  band_r_q [N_BARS];
  logic [ACC_W-1:0]  band_b_q [N_BARS];
  logic [ACC_W:0]    top_w, mid_w, bot_w;
  logic [1:0]        colour_d, colour_q, shape_d, shape_q;
  logic [3:0]        cand_new, cand_q, cnt_d, cnt_q, result_q;
  logic              publish, rdy_q, overrun_q;

  // Blue has only two bits; the extra LSB puts it on the same 0..7 scale as red.
  assign pix_r   = pixel_in_i[7:5];
  assign pix_g   = pixel_in_i[4:2];
  assign pix_b   = {pixel_in_i[1:0], 1'b0};
  assign vs_rise = vga_vsync_neg_i & ~vs_q;
  assign in_x    = (vga_pixel_x_i >= X0) && (vga_pixel_x_i < X1);
  assign in_y    = (vga_pixel_y_i >= Y0) && (vga_pixel_y_i < Y1);

  for (genvar gi = 0; gi < N_BARS; gi++) begin : g_band
    localparam logic [9:0] LO = 10'(BAR_Y0 + gi * BAR_PITCH);
    localparam logic [9:0] HI = 10'(BAR_Y0 + gi * BAR_PITCH + BAR_H);
    assign band_hit[gi] = pix_en && (vga_pixel_y_i >= LO) && (vga_pixel_y_i < HI);
  end

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                input logic [2:0] inc);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + (ACC_W+1)'(inc);
    return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    pix_en  = 1'b0;
    vote_en = 1'b0;
    case (state_q)
      S_IDLE: if (vs_rise) begin
        clr     = 1'b1;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (!vga_vsync_neg_i)          state_d = S_IDLE;
        else if (vga_pixel_y_i >= Y1)  state_d = S_COLOR;
        else                           pix_en  = href_i && in_x;
      end
      S_COLOR: state_d = S_SHAPE;
      S_SHAPE: state_d = S_VOTE;
      S_VOTE: begin
        vote_en = 1'b1;
        state_d = S_WAIT_VS;
      end
      S_WAIT_VS: if (!vga_vsync_neg_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    colour_d = COL_NONE;
    if (r_sum_q > b_sum_q && (r_sum_q - b_sum_q) > C_MARGIN && r_sum_q > C_MIN)
      colour_d = COL_RED;
    else if (b_sum_q > r_sum_q && (b_sum_q - r_sum_q) > C_MARGIN && b_sum_q > C_MIN)
      colour_d = COL_BLUE;
  end

  // Shape is judged on the bands of whichever colour won the frame.
  always_comb begin
    if (colour_q == COL_BLUE) begin
      top_w = {1'b0, band_b_q[0]};
      mid_w = {1'b0, band_b_q[MID]};
      bot_w = {1'b0, band_b_q[N_BARS-1]};
    end else begin
      top_w = {1'b0, band_r_q[0]};
      mid_w = {1'b0, band_r_q[MID]};
      bot_w = {1'b0, band_r_q[N_BARS-1]};
    end
    shape_d = SH_SQ;
    if (colour_q == COL_NONE)                                         shape_d = SH_NONE;
    else if (mid_w > top_w + S_MARGIN && mid_w > bot_w + S_MARGIN)    shape_d = SH_DIA;
    else if (bot_w > top_w + S_MARGIN)                                shape_d = SH_TRI;
  end

  always_comb begin
    cand_new = {colour_q, shape_q};
    if (cand_new == cand_q) cnt_d = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
    else                    cnt_d = 4'd1;
    publish = vote_en && (cnt_d == VF) && (cand_new != result_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // Held high so a reset released mid-frame does not look like a frame start.
      vs_q      <= 1'b1;
      r_sum_q   <= '0;
      g_sum_q   <= '0;
      b_sum_q   <= '0;
      for (int k = 0; k < N_BARS; k++) begin
        band_r_q[k] <= '0;
        band_b_q[k] <= '0;
      end
      colour_q  <= COL_NONE;
      shape_q   <= SH_NONE;
      cand_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      rdy_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      vs_q <= vga_vsync_neg_i;
      if (clr) begin
        r_sum_q <= '0;
        g_sum_q <= '0;
        b_sum_q <= '0;
        for (int k = 0; k < N_BARS; k++) begin
          band_r_q[k] <= '0;
          band_b_q[k] <= '0;
        end
      end else begin
        if (pix_en && in_y) begin
          r_sum_q <= sat_add(r_sum_q, pix_r);
          g_sum_q <= sat_add(g_sum_q, pix_g);
          b_sum_q <= sat_add(b_sum_q, pix_b);
        end
        for (int k = 0; k < N_BARS; k++) begin
          if (band_hit[k]) begin
            band_r_q[k] <= sat_add(band_r_q[k], pix_r);
            band_b_q[k] <= sat_add(band_b_q[k], pix_b);
          end
        end
      end
      if (state_q == S_COLOR) colour_q <= colour_d;
      if (state_q == S_SHAPE) shape_q  <= shape_d;
      if (vote_en) begin
        cand_q <= cand_new;
        cnt_q  <= cnt_d;
      end
      // A publish beats a same-cycle ACK; it only counts as overrun if nobody acked.
      overrun_q <= 1'b0;
      if (publish) begin
        result_q  <= cand_new;
        rdy_q     <= 1'b1;
        overrun_q <= rdy_q && !result_ack_i;
      end else if (rdy_q && result_ack_i) begin
        rdy_q <= 1'b0;
      end
    end
  end

  assign result_o  = result_q;
  assign rdy_o     = rdy_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_treasure_frame_classifier.sv
// Directed frame-level bench for treasure_frame_classifier: synthetic frames with hand-computed
// classifications; a second instance with 12-bit accumulators exercises saturation.
module tb_treasure_frame_classifier;

  localparam int K_RED_FULL = 0, K_WHITE = 1, K_RED_SQ = 2, K_BLUE_DIA = 3, K_RED_TRI = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pix;
  logic       href;
  logic [9:0] vx, vy;
  logic       vs;
  logic       ack;
  logic [3:0] result, result_s;
  logic       rdy, rdy_s, ov, ov_s;

  int n_tests = 0;
  int n_fail  = 0;
  int ov_cnt  = 0;
  int ov_cnt_s = 0;
  int ov_base;

  treasure_frame_classifier dut (
    .clk_i(clk), .rst_ni(rst_n), .pixel_in_i(pix), .href_i(href),
    .vga_pixel_x_i(vx), .vga_pixel_y_i(vy), .vga_vsync_neg_i(vs),
    .result_ack_i(ack), .result_o(result), .rdy_o(rdy), .overrun_o(ov)
  );

  treasure_frame_classifier #(.ACC_W(12)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .pixel_in_i(pix), .href_i(href),
    .vga_pixel_x_i(vx), .vga_pixel_y_i(vy), .vga_vsync_neg_i(vs),
    .result_ack_i(ack), .result_o(result_s), .rdy_o(rdy_s), .overrun_o(ov_s)
  );

  always #5 clk = ~clk;

  // Counts cycles with OVERRUN high, so a one-cycle pulse adds exactly one.
  always @(posedge clk) begin
    #1;
    if (ov)   ov_cnt++;
    if (ov_s) ov_cnt_s++;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic in_band(input int y);
    return (y >= 47 && y <= 50) || (y >= 72 && y <= 75) || (y >= 97 && y <= 100);
  endfunction

  function automatic logic row_active(input int kind, input int y);
    case (kind)
      K_RED_FULL, K_WHITE:  return y >= 28 && y <= 115;
      K_RED_SQ, K_BLUE_DIA: return in_band(y);
      default:              return in_band(y) || y == 46 || y == 51;
    endcase
  endfunction

  function automatic logic [7:0] pix_of(input int kind, input int x, input int y);
    if (x < 35 || x > 140) return 8'h00;
    case (kind)
      K_RED_FULL, K_RED_SQ: return 8'hE0;
      K_WHITE:              return 8'hFF;
      K_BLUE_DIA:           return (y >= 72 && y <= 75) || x <= 60 ? 8'h03 : 8'h00;
      default: begin
        if (y == 46 || y == 51) return 8'hE0;
        if (y <= 75)            return x <= 60 ? 8'hE0 : 8'h00;
        return x <= 87 ? 8'hE0 : 8'h00;
      end
    endcase
  endfunction

  task automatic frame_start();
    vs = 1'b0; href = 1'b0; vx = '0; vy = '0;
    repeat (3) @(negedge clk);
    vs = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame_rows(input int kind, input int first, input int stop);
    for (int y = first; y < stop; y++) begin
      if (row_active(kind, y)) begin
        for (int x = 34; x <= 141; x++) begin
          vy = 10'(y); vx = 10'(x); href = 1'b1; pix = pix_of(kind, x, y);
          @(negedge clk);
        end
      end
    end
    href = 1'b0; pix = '0;
  endtask

  // ack_pub raises ACK for exactly the cycle sampled by the publish edge.
  task automatic frame_end(input bit ack_pub);
    href = 1'b0; vy = 10'd116; vx = '0;
    repeat (3) @(negedge clk);
    if (ack_pub) ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input int kind, input bit ack_pub, input string name);
    frame_start();
    frame_rows(kind, 27, 116);
    frame_end(ack_pub);
    $display("[TB] frame %s: result=%b rdy=%b ovr_cycles=%0d", name, result, rdy, ov_cnt);
  endtask

  task automatic pulse_ack(input string name);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    $display("[TB] ack %s: result=%b rdy=%b", name, result, rdy);
  endtask

  initial begin
    rst_n = 1'b0; pix = '0; href = 1'b0; vx = '0; vy = '0; vs = 1'b0; ack = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_result", 32'(result), 32'h0);
    check_eq("reset_rdy", 32'(rdy), 32'h0);
    check_eq("reset_overrun", 32'(ov), 32'h0);
    check_eq("reset_result_sat", 32'(result_s), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Uniform red: publish only after the second identical frame.
    run_frame(K_RED_FULL, 1'b0, "red_full_1");
    check_eq("red1_rdy", 32'(rdy), 32'h0);
    check_eq("red1_result", 32'(result), 32'h0);
    run_frame(K_RED_FULL, 1'b0, "red_full_2");
    check_eq("red2_result", 32'(result), 32'hA);
    check_eq("red2_rdy", 32'(rdy), 32'h1);

    // Blue diamond published over an unacknowledged result -> overrun.
    ov_base = ov_cnt;
    run_frame(K_BLUE_DIA, 1'b0, "blue_dia_1");
    check_eq("dia1_result_held", 32'(result), 32'hA);
    check_eq("dia1_no_overrun", 32'(ov_cnt - ov_base), 32'h0);
    run_frame(K_BLUE_DIA, 1'b0, "blue_dia_2");
    check_eq("dia2_result", 32'(result), 32'h7);
    check_eq("dia2_rdy", 32'(rdy), 32'h1);
    check_eq("dia2_overrun_pulse", 32'(ov_cnt - ov_base), 32'h1);
    pulse_ack("after_dia");
    check_eq("ack_clears_rdy", 32'(rdy), 32'h0);
    check_eq("ack_keeps_result", 32'(result), 32'h7);
    pulse_ack("idle");
    check_eq("ack_rdy0_ignored", 32'(rdy), 32'h0);

    // Alternating colours after reset never reach the vote threshold.
    rst_n = 1'b0;
    #2;
    check_eq("rst2_result", 32'(result), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      run_frame((i % 2 == 0) ? K_RED_SQ : K_BLUE_DIA, 1'b0, "alternate");
      check_eq("alt_rdy", 32'(rdy), 32'h0);
    end
    check_eq("alt_result", 32'(result), 32'h0);

    // Discarded frame between two red triangles leaves the vote count intact.
    run_frame(K_RED_TRI, 1'b0, "red_tri_1");
    check_eq("tri1_rdy", 32'(rdy), 32'h0);
    frame_start();
    frame_rows(K_RED_TRI, 27, 60);
    $display("[TB] frame red_tri_dropped at row 60: result=%b rdy=%b", result, rdy);
    run_frame(K_RED_TRI, 1'b0, "red_tri_2");
    check_eq("tri2_result", 32'(result), 32'h9);
    check_eq("tri2_rdy", 32'(rdy), 32'h1);

    // Publish and ACK on the same edge: RDY stays set, no overrun.
    ov_base = ov_cnt;
    run_frame(K_BLUE_DIA, 1'b0, "blue_dia_3");
    check_eq("dia3_result_held", 32'(result), 32'h9);
    run_frame(K_BLUE_DIA, 1'b1, "blue_dia_4_ack");
    check_eq("same_edge_result", 32'(result), 32'h7);
    check_eq("same_edge_rdy", 32'(rdy), 32'h1);
    check_eq("same_edge_no_overrun", 32'(ov_cnt - ov_base), 32'h0);
    pulse_ack("after_same_edge");
    check_eq("ack2_rdy", 32'(rdy), 32'h0);

    // Re-voting the already published code does not republish it.
    run_frame(K_RED_SQ, 1'b0, "red_sq");
    run_frame(K_BLUE_DIA, 1'b0, "blue_dia_5");
    run_frame(K_BLUE_DIA, 1'b0, "blue_dia_6");
    check_eq("no_republish_rdy", 32'(rdy), 32'h0);
    check_eq("no_republish_result", 32'(result), 32'h7);

    // Reset mid-frame: the rest of that frame must be ignored.
    frame_start();
    frame_rows(K_RED_TRI, 27, 60);
    rst_n = 1'b0;
    #2;
    check_eq("midrst_result", 32'(result), 32'h0);
    check_eq("midrst_rdy", 32'(rdy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    frame_rows(K_RED_TRI, 60, 116);
    frame_end(1'b0);
    run_frame(K_RED_TRI, 1'b0, "red_tri_post_reset");
    check_eq("post_reset_rdy", 32'(rdy), 32'h0);

    // White frames: wide accumulators see red, 12-bit ones saturate to a tie.
    ov_base = ov_cnt_s;
    run_frame(K_WHITE, 1'b0, "white_1");
    run_frame(K_WHITE, 1'b0, "white_2");
    check_eq("white_result", 32'(result), 32'hA);
    check_eq("white_rdy", 32'(rdy), 32'h1);
    check_eq("sat_result", 32'(result_s), 32'h0);
    check_eq("sat_rdy", 32'(rdy_s), 32'h0);
    check_eq("sat_no_overrun", 32'(ov_cnt_s - ov_base), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
